// File: rtl/wb_io_ctrl_pkg.sv
// Shared constants for the Wishbone user-pad controller: register word offsets,
// default pad count and the output-enable reset pattern.
package wb_io_ctrl_pkg;

  localparam int NIO_DEF = 12;

  // Word indices as seen on wbs_adr_i[7:2]
  localparam logic [5:0] OFF_OUT   = 6'h00;
  localparam logic [5:0] OFF_OEB   = 6'h01;
  localparam logic [5:0] OFF_IN    = 6'h02;
  localparam logic [5:0] OFF_IEN   = 6'h03;
  localparam logic [5:0] OFF_ISTAT = 6'h04;
  localparam logic [5:0] OFF_ECNT  = 6'h05;

  localparam logic [31:0] OEB_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_io_ctrl_io_sync_edge.sv
// Pad input synchronizer followed by one extra flop so that rising edges can be
// detected on the synchronized value.
module io_sync_edge
  import wb_io_ctrl_pkg::*;
#(
  parameter int NIO         = NIO_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NIO-1:0] io_in,
  output logic [NIO-1:0] sync,
  output logic [NIO-1:0] rise
);

  logic [NIO-1:0] sync_d [SYNC_STAGES];
  logic [NIO-1:0] sync_q [SYNC_STAGES];
  logic [NIO-1:0] prev_d;
  logic [NIO-1:0] prev_q;

  always_comb begin
    sync_d[0] = io_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // prev clears to 0, so a pad already high at reset release reports one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;

endmodule

// File: rtl/wb_io_ctrl.sv
// Wishbone classic slave owning the user pads: output/enable registers, input
// readback, per-pin rising-edge flags with enable, edge counter and level irq.
module wb_io_ctrl
  import wb_io_ctrl_pkg::*;
#(
  parameter int          NIO         = NIO_DEF,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic [NIO-1:0] io_in,
  output logic [NIO-1:0] io_out,
  output logic [NIO-1:0] io_oeb,
  output logic           irq
);

  logic [NIO-1:0] sync;
  logic [NIO-1:0] rise;

  io_sync_edge #(
    .NIO         (NIO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .io_in (io_in),
    .sync  (sync),
    .rise  (rise)
  );

  logic           sel, req, wr, hit_en;
  logic [5:0]     off;
  logic [31:0]    lane_mask;
  logic [NIO-1:0] wmask, wdat;
  logic [31:0]    rdata;

  logic [NIO-1:0] out_d, out_q;
  logic [NIO-1:0] oeb_d, oeb_q;
  logic [NIO-1:0] ien_d, ien_q;
  logic [NIO-1:0] istat_d, istat_q;
  logic [15:0]    ecnt_d, ecnt_q;
  logic           irq_d, irq_q;
  logic           ack_d, ack_q;
  logic [31:0]    dat_d, dat_q;

  if (NIO < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{wbs_dat_i[31:NIO], lane_mask[31:NIO]};
  end

  always_comb begin
    sel       = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    // A request still held while ack is up is the same transfer, not a new one
    req       = sel & ~ack_q;
    wr        = req & wbs_we_i;
    off       = wbs_adr_i[7:2];
    lane_mask = byte_mask(wbs_sel_i);
    wmask     = lane_mask[NIO-1:0];
    wdat      = wbs_dat_i[NIO-1:0];
    hit_en    = |(rise & ien_q);

    out_d   = out_q;
    oeb_d   = oeb_q;
    ien_d   = ien_q;
    istat_d = istat_q;
    ecnt_d  = ecnt_q;
    if (wr) begin
      case (off)
        OFF_OUT:   out_d   = (out_q & ~wmask) | (wdat & wmask);
        OFF_OEB:   oeb_d   = (oeb_q & ~wmask) | (wdat & wmask);
        OFF_IEN:   ien_d   = (ien_q & ~wmask) | (wdat & wmask);
        OFF_ISTAT: istat_d = istat_q & ~(wdat & wmask);
        OFF_ECNT:  ecnt_d  = '0;
        default:   ;
      endcase
    end
    // Applied after the bus write so a new edge beats a clear in the same cycle
    istat_d = istat_d | (rise & ien_q);
    ecnt_d  = ecnt_d + {15'd0, hit_en};

    rdata = '0;
    case (off)
      OFF_OUT:   rdata = 32'(out_q);
      OFF_OEB:   rdata = 32'(oeb_q);
      OFF_IN:    rdata = 32'(sync);
      OFF_IEN:   rdata = 32'(ien_q);
      OFF_ISTAT: rdata = 32'(istat_q);
      OFF_ECNT:  rdata = {16'd0, ecnt_q};
      default:   rdata = '0;
    endcase

    ack_d = req;
    dat_d = (req & ~wbs_we_i) ? rdata : '0;
    irq_d = |(istat_q & ien_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q   <= '0;
      oeb_q   <= OEB_RST[NIO-1:0];
      ien_q   <= '0;
      istat_q <= '0;
      ecnt_q  <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      ien_q   <= ien_d;
      istat_q <= istat_d;
      ecnt_q  <= ecnt_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign irq       = irq_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule
